// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter that shares one combinational ALU between NREQ requesters.
// The winner's opcode and operands are registered toward the ALU, the result is
// captured one cycle later and returned with the requester ID on a valid/ready
// response channel.
module alu_share_arbiter #(
   parameter int NREQ = 2,
   parameter int IDW  = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NREQ-1:0]      req_valid,
   output logic [NREQ-1:0]      req_ready,
   input  logic [6*NREQ-1:0]    req_op,
   input  logic [32*NREQ-1:0]   req_a,
   input  logic [32*NREQ-1:0]   req_b,
   output logic [5:0]           alu_op,
   output logic [31:0]          alu_a,
   output logic [31:0]          alu_b,
   input  logic [31:0]          alu_out,
   input  logic                 alu_zero,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [IDW-1:0]       rsp_id,
   output logic [31:0]          rsp_data,
   output logic                 rsp_zero
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_e;

   state_e          state_q, state_d;
   logic [IDW-1:0]  last_grant_q, last_grant_d;
   logic [IDW-1:0]  grant_id_q, grant_id_d;
   logic [5:0]      alu_op_q, alu_op_d;
   logic [31:0]     alu_a_q, alu_a_d;
   logic [31:0]     alu_b_q, alu_b_d;
   logic            rsp_valid_q, rsp_valid_d;
   logic [IDW-1:0]  rsp_id_q, rsp_id_d;
   logic [31:0]     rsp_data_q, rsp_data_d;
   logic            rsp_zero_q, rsp_zero_d;

   logic            arb_allowed;
   logic            grant_found;
   logic [IDW-1:0]  grant_idx;
   logic            accept;
   logic [5:0]      win_op;
   logic [31:0]     win_a;
   logic [31:0]     win_b;

   // Round-robin search starting one past the last grant; drives the one-hot ready.
   always_comb begin
      // NOTE: every variable gets a default before any branch, otherwise a path
      // that skips an assignment infers a latch.
      arb_allowed = !rst && ((state_q == IDLE) || ((state_q == RESP) && rsp_ready));
      grant_found = 1'b0;
      grant_idx   = '0;
      for (int k = 1; k <= NREQ; k++) begin
         for (int i = 0; i < NREQ; i++) begin
            if (!grant_found && req_valid[i] && (i == (int'(last_grant_q) + k) % NREQ)) begin
               grant_found = 1'b1;
               grant_idx   = IDW'(i);
            end
         end
      end
      accept    = arb_allowed && grant_found;
      req_ready = '0;
      for (int i = 0; i < NREQ; i++) begin
         req_ready[i] = accept && (int'(grant_idx) == i);
      end
   end

   // Select the winning requester's payload from the packed request buses.
   always_comb begin
      win_op = '0;
      win_a  = '0;
      win_b  = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (int'(grant_idx) == i) begin
            win_op = req_op[6*i +: 6];
            win_a  = req_a[32*i +: 32];
            win_b  = req_b[32*i +: 32];
         end
      end
   end

   // Next-state logic: accept into EXEC, capture result into RESP, drain on rsp_ready.
   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      grant_id_d   = grant_id_q;
      alu_op_d     = alu_op_q;
      alu_a_d      = alu_a_q;
      alu_b_d      = alu_b_q;
      rsp_valid_d  = rsp_valid_q;
      rsp_id_d     = rsp_id_q;
      rsp_data_d   = rsp_data_q;
      rsp_zero_d   = rsp_zero_q;

      // ALU inputs only move on an accept so the shared ALU stays quiet when idle.
      if (accept) begin
         alu_op_d     = win_op;
         alu_a_d      = win_a;
         alu_b_d      = win_b;
         grant_id_d   = grant_idx;
         last_grant_d = grant_idx;
      end

      case (state_q)
         IDLE: begin
            if (accept) state_d = EXEC;
         end
         EXEC: begin
            rsp_data_d  = alu_out;
            rsp_zero_d  = alu_zero;
            rsp_id_d    = grant_id_q;
            rsp_valid_d = 1'b1;
            state_d     = RESP;
         end
         RESP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = accept ? EXEC : IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State register with synchronous reset; reset drops any in-flight transaction.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples its pre-edge value regardless of statement order.
      if (rst) begin
         state_q      <= IDLE;
         last_grant_q <= IDW'(NREQ - 1);
         grant_id_q   <= '0;
         alu_op_q     <= '0;
         alu_a_q      <= '0;
         alu_b_q      <= '0;
         rsp_valid_q  <= 1'b0;
         rsp_id_q     <= '0;
         rsp_data_q   <= '0;
         rsp_zero_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         grant_id_q   <= grant_id_d;
         alu_op_q     <= alu_op_d;
         alu_a_q      <= alu_a_d;
         alu_b_q      <= alu_b_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_id_q     <= rsp_id_d;
         rsp_data_q   <= rsp_data_d;
         rsp_zero_q   <= rsp_zero_d;
      end
   end

   assign alu_op    = alu_op_q;
   assign alu_a     = alu_a_q;
   assign alu_b     = alu_b_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_id    = rsp_id_q;
   assign rsp_data  = rsp_data_q;
   assign rsp_zero  = rsp_zero_q;

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares one combinational ALU between NREQ independent requesters; each request carries its own 6-bit opcode and two 32-bit operands.
- Round-robin arbitration, registered operands toward the ALU, result captured one cycle later and returned with the originating requester ID over a valid/ready response channel.
- Sits between the issue logic and the shared ALU instance.

Parameters:
- NREQ, 2, number of requesters; supported range 2..4.
- IDW, 2, width of requester ID; must satisfy 2^IDW >= NREQ.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NREQ  request pending, one bit per requester.
- req_ready  out  NREQ  one-hot grant/accept; transfer when valid&ready.
- req_op  in  6*NREQ  opcode, requester i in bits [6i+5:6i].
- req_a  in  32*NREQ  operand A, requester i in bits [32i+31:32i].
- req_b  in  32*NREQ  operand B, same packing.
- alu_op  out  6  registered opcode to shared ALU.
- alu_a  out  32  registered operand A to ALU.
- alu_b  out  32  registered operand B to ALU.
- alu_out  in  32  ALU result (combinational from alu_op/a/b).
- alu_zero  in  1  ALU zero flag.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer accepts response.
- rsp_id  out  IDW  index of requester that issued this result.
- rsp_data  out  32  captured ALU result.
- rsp_zero  out  1  captured zero flag.

Behaviour:
- Reset (rst=1 at an edge): state=IDLE; rsp_valid=0, rsp_data=0, rsp_zero=0, rsp_id=0; alu_op/alu_a/alu_b=0; last_grant=NREQ-1 (requester 0 wins first); req_ready=0 while rst is high.
- Reset mid-operation discards the in-flight transaction; no response is ever produced for it.
- FSM states: IDLE, EXEC, RESP.
- Arbitration (IDLE, or RESP when rsp_valid&rsp_ready): search req_valid starting at (last_grant+1) mod NREQ, wrapping; the first set bit wins. req_ready is combinational: exactly the winner's bit is 1, all others 0. When no request is pending or arbitration is not allowed, req_ready=0.
- On accept: latch the winner's op/a/b into alu_op/alu_a/alu_b, latch the winner index into the ID register and last_grant, then go to EXEC.
- EXEC (1 cycle): capture alu_out into rsp_data and alu_zero into rsp_zero; set rsp_id; set rsp_valid=1; go to RESP.
- RESP: hold rsp_* stable while rsp_valid=1 and rsp_ready=0.
  - On rsp_ready=1 with no new accept: rsp_valid=0, go to IDLE.
  - On rsp_ready=1 with an accept in the same cycle: rsp_valid=0, go to EXEC with the new operands.
- Latency: accept at cycle N gives rsp_valid=1 at cycle N+2. Maximum throughput is one result per 2 cycles with rsp_ready held at 1.
- alu_op/alu_a/alu_b hold their last accepted values outside accept cycles, so the ALU inputs do not toggle when idle.
- Opcodes pass through unfiltered. Defined codes: 0 and, 1 or, 2 add, 6 sub, 7 nand, 12 nor, 13 xor. For undefined codes the ALU returns 0, so rsp_data=0 and rsp_zero=1.
- Arithmetic: 32-bit wrap-around is performed by the ALU; the arbiter does no arithmetic.
- Requesters must hold req_valid and payload stable until accepted. A request deasserted before grant is simply not served.
- A requester that is not granted sees req_ready=0. Starvation-free: any continuously valid requester is granted within NREQ accepts.

Test Plan:
- Single add: reset, then req 0 valid op=2 a=5 b=7, rsp_ready=1 -> req_ready=01 at cycle N; at N+2 rsp_valid=1, rsp_id=0, rsp_data=12, rsp_zero=0.
- Sub to zero and wrap: req 1 op=6 a=9 b=9 -> rsp_data=0, rsp_zero=1, rsp_id=1. Then op=2 a=32'hFFFFFFFF b=1 -> rsp_data=0, rsp_zero=1.
- Round robin: both valid continuously with distinct ops (req0 op=1 a=3 b=4 -> 7; req1 op=13 a=3 b=5 -> 6) -> grants alternate 0,1,0,1; rsp_id sequence 0,1,0,1; results 7,6,7,6; one response every 2 cycles.
- Backpressure: rsp_ready=0 for 5 cycles after rsp_valid -> rsp_id/rsp_data/rsp_zero stable and req_ready=0 throughout. When rsp_ready rises with req0 pending, the accept happens in that same cycle.
- Undefined opcode: op=3 a=1 b=1 -> rsp_data=0, rsp_zero=1.
- Reset mid-op: assert rst during EXEC -> next cycle rsp_valid=0, all outputs at reset values, no response for the dropped request. The first post-reset grant goes to requester 0 when both are valid.
